ppi_bus_ctrl: RTL
=================

# ppi_bus_ctrl

Read/write control and control-word register for the 8255A PPI. Synchronises the asynchronous host strobes (nCs, nRe, nWr, A, D) into the PPI clock domain, decodes accesses, and holds the control word. Drives the port A/B/C blocks directly: they consume `controlword`, `portc_bsr` and the per-port strobes produced here.

## Interface
Parameters:
- `CW_RESET`, 8'h9B: control word after reset (mode 0, all ports input).
- `SYNC_STAGES`, 2: synchroniser depth for all host inputs (legal 2..3).

Ports:
- `clk` in 1: PPI clock, rising edge.
- `nReset` in 1: synchronous, active-low reset.
- `nCs` in 1: host chip select, active low, asynchronous.
- `nRe` in 1: host read strobe, active low, asynchronous.
- `nWr` in 1: host write strobe, active low, asynchronous.
- `A` in 2: host address (00=A, 01=B, 10=C, 11=control).
- `D` in 8: host data bus, write direction.
- `controlword` out 8: current control word.
- `portc_bsr` out 8: port C output latch image from bit set/reset.
- `wr_strobe` out 3: one-hot, one-cycle write pulse to port A/B/C; bit0=A.
- `wr_data` out 8: data committed with `wr_strobe`, held until next commit.
- `rd_en` out 3: one-hot, high while a read of port A/B/C is active.
- `mode_load` out 1: one-cycle pulse when a new control word is loaded.
- `bus_err` out 1: one-cycle pulse on illegal access.

## Operation
- All of nCs, nRe, nWr, A, D pass through `SYNC_STAGES` flops; FSM sees only synchronised copies (s_*).
- FSM states: IDLE, WRITE, READ, COMMIT.
- IDLE -> WRITE when s_nCs=0 and s_nWr=0 (takes priority). If s_nRe=0 also, pulse `bus_err`; write still proceeds.
- IDLE -> READ when s_nCs=0, s_nRe=0, s_nWr=1.
- WRITE: capture s_A and s_D every cycle (last-value-wins). Exit to COMMIT when s_nWr=1 or s_nCs=1.
- COMMIT (one cycle), action by captured address:
  - A=00/01/10: `wr_data`<=data; `wr_strobe` one-hot bit set this cycle.
  - A=11, D7=1: `controlword`<=data; `portc_bsr`<=8'h00; `mode_load` pulses.
  - A=11, D7=0: bit set/reset, see Configuration.
  - Then -> IDLE.
- READ: `rd_en` one-hot for s_A while in READ; s_A=11 gives `rd_en`=000 and one `bus_err` pulse on entry. Exit to IDLE when s_nRe=1 or s_nCs=1. A change mid-read retargets `rd_en` the next cycle.
- Reset (any state, including mid-WRITE): state IDLE, `controlword`=CW_RESET, `portc_bsr`=00, `wr_data`=00, `wr_strobe`=000, `rd_en`=000, `mode_load`=0, `bus_err`=0, sync flops=1 (strobes) / 0 (A, D). No commit for an interrupted write.

## Timing
- All outputs are registered.
- Host edge to FSM visibility: `SYNC_STAGES` clocks.
- nWr rising sampled at edge N: COMMIT entered at edge N+`SYNC_STAGES`.
  - `wr_strobe`, `mode_load`, `controlword`, `portc_bsr` update at that edge.
  - Pulses drop at the following edge.
- Write-to-write gap: at least one IDLE cycle after COMMIT.
- `rd_en` asserts one clock after s_nRe falls and deasserts one clock after s_nRe rises.
- Host strobe low time must be ≥ `SYNC_STAGES`+1 clocks. Shorter pulses may be dropped; there is no partial commit.

## Configuration
- `PPI_BSR_EN` defined: write A=11 with D7=0 sets `portc_bsr[D3:D1]` to D0; `controlword` unchanged; no `mode_load`.
- Undefined: such writes are ignored; `bus_err` pulses; `portc_bsr` only clears on mode load and reset.

## Test plan
- Reset: hold nReset=0 two clocks -> `controlword`=9B, `portc_bsr`=00, all strobes 0, state IDLE.
- Write control A=11 D=80 -> `controlword`=80 exactly SYNC_STAGES clocks after nWr rise; `mode_load` one cycle; `portc_bsr`=00.
- Write port B A=01 D=5A -> `wr_strobe`=010 one cycle, `wr_data`=5A; `controlword` unchanged.
- With `PPI_BSR_EN`: write A=11 D=0B then D=0A -> `portc_bsr` bit5 =1, then 0. Without the macro: `bus_err` pulses twice and `portc_bsr` stays 00.
- Read A=10 for 5 clocks -> `rd_en`=100 for the read window; read A=11 -> `rd_en`=000 plus one `bus_err` pulse.
- nReset asserted mid-write (nWr low) -> no `wr_strobe` and outputs at reset values. nRe and nWr low together -> `bus_err` pulse, then normal write commit.

Source files
------------

// File: rtl/ppi_bus_ctrl.sv
// ppi_bus_ctrl: 8255A read/write control and control-word register.
// Synchronises the asynchronous host strobes, address and data into the
// PPI clock domain. It decodes reads and writes. It owns the control word
// and the port C bit set/reset image.
// Optional feature: define PPI_BSR_EN to enable port C bit set/reset writes
// (A=11, D7=0). Without it such writes are rejected with a bus_err pulse.
module ppi_bus_ctrl #(
    parameter logic [7:0] CW_RESET    = 8'h9B,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       nCs,
    input  logic       nRe,
    input  logic       nWr,
    input  logic [1:0] A,
    input  logic [7:0] D,
    output logic [7:0] controlword,
    output logic [7:0] portc_bsr,
    output logic [2:0] wr_strobe,
    output logic [7:0] wr_data,
    output logic [2:0] rd_en,
    output logic       mode_load,
    output logic       bus_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        READ   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t state;

    // Synchroniser chains. Index 0 is the first flop.
    logic [SYNC_STAGES-1:0]      sy_ncs, sy_nre, sy_nwr;
    logic [SYNC_STAGES-1:0][1:0] sy_a;
    logic [SYNC_STAGES-1:0][7:0] sy_d;

    logic       s_ncs, s_nre, s_nwr;
    logic [1:0] s_a;
    logic [7:0] s_d;

    // Address/data captured during WRITE; the last value seen wins.
    logic [1:0] cap_a;
    logic [7:0] cap_d;

    assign s_ncs = sy_ncs[SYNC_STAGES-1];
    assign s_nre = sy_nre[SYNC_STAGES-1];
    assign s_nwr = sy_nwr[SYNC_STAGES-1];
    assign s_a   = sy_a[SYNC_STAGES-1];
    assign s_d   = sy_d[SYNC_STAGES-1];

    // Port address to one-hot port select; the control address selects no port.
    function automatic logic [2:0] port_sel(input logic [1:0] a);
        logic [2:0] r;
        r = 3'b000;
        case (a)
            2'b00:   r = 3'b001;
            2'b01:   r = 3'b010;
            2'b10:   r = 3'b100;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    // Shift the host inputs through the synchroniser. Strobes idle high.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            sy_ncs <= '1;
            sy_nre <= '1;
            sy_nwr <= '1;
            sy_a   <= '0;
            sy_d   <= '0;
        end else begin
            sy_ncs <= {sy_ncs[SYNC_STAGES-2:0], nCs};
            sy_nre <= {sy_nre[SYNC_STAGES-2:0], nRe};
            sy_nwr <= {sy_nwr[SYNC_STAGES-2:0], nWr};
            sy_a   <= {sy_a[SYNC_STAGES-2:0], A};
            sy_d   <= {sy_d[SYNC_STAGES-2:0], D};
        end
    end

    // Access FSM. All outputs are registered here.
    // Commit effects land on the same edge that enters COMMIT. The COMMIT
    // state then gives the mandatory idle gap before the next access.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            state       <= IDLE;
            cap_a       <= '0;
            cap_d       <= '0;
            controlword <= CW_RESET;
            portc_bsr   <= '0;
            wr_data     <= '0;
            wr_strobe   <= '0;
            rd_en       <= '0;
            mode_load   <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            wr_strobe <= '0;
            mode_load <= 1'b0;
            bus_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!s_ncs && !s_nwr) begin
                        // A write wins over a simultaneous read, which is flagged.
                        state <= WRITE;
                        cap_a <= s_a;
                        cap_d <= s_d;
                        rd_en <= '0;
                        if (!s_nre) bus_err <= 1'b1;
                    end else if (!s_ncs && !s_nre) begin
                        state <= READ;
                        rd_en <= port_sel(s_a);
                        if (s_a == 2'b11) bus_err <= 1'b1;
                    end else begin
                        rd_en <= '0;
                    end
                end
                WRITE: begin
                    if (s_nwr || s_ncs) begin
                        state <= COMMIT;
                        if (cap_a != 2'b11) begin
                            wr_data   <= cap_d;
                            wr_strobe <= port_sel(cap_a);
                        end else if (cap_d[7]) begin
                            controlword <= cap_d;
                            portc_bsr   <= '0;
                            mode_load   <= 1'b1;
                        end else begin
`ifdef PPI_BSR_EN
                            portc_bsr[cap_d[3:1]] <= cap_d[0];
`else
                            bus_err <= 1'b1;
`endif
                        end
                    end else begin
                        cap_a <= s_a;
                        cap_d <= s_d;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                end
                READ: begin
                    if (s_nre || s_ncs) begin
                        state <= IDLE;
                        rd_en <= '0;
                    end else begin
                        rd_en <= port_sel(s_a);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
